loop_nest_agu: RTL and testbench



---
 rtl/loop_nest_agu.sv | 168 ++++++++++++++++
 tb/tb_loop_nest_agu.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_nest_agu.sv
// Three-level nested-loop address generator: emits (i, j, k, addr) beats in
// row-major order with a valid/ready handshake, using only incremental adds.
module loop_nest_agu #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] bound_i,
  input  logic [W-1:0] bound_j,
  input  logic [W-1:0] bound_k,
  input  logic [W-1:0] base,
  input  logic [W-1:0] stride_i,
  input  logic [W-1:0] stride_j,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx_i,
  output logic [W-1:0] idx_j,
  output logic [W-1:0] idx_k,
  output logic [W-1:0] addr,
  output logic         last,
  output logic         busy,
  output logic         done
);

  localparam logic [W-1:0] ONE = W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] bi_q, bi_d;
  logic [W-1:0] bj_q, bj_d;
  logic [W-1:0] bk_q, bk_d;
  logic [W-1:0] si_q, si_d;
  logic [W-1:0] sj_q, sj_d;
  logic [W-1:0] i_q, i_d;
  logic [W-1:0] j_q, j_d;
  logic [W-1:0] k_q, k_d;
  logic [W-1:0] row_q, row_d;
  logic [W-1:0] col_q, col_d;
  logic [W-1:0] addr_q, addr_d;

  logic         i_end, j_end, k_end;
  logic         all_nz;
  logic [W-1:0] next_col;
  logic [W-1:0] next_row;

  assign i_end    = (i_q == bi_q - ONE);
  assign j_end    = (j_q == bj_q - ONE);
  assign k_end    = (k_q == bk_q - ONE);
  assign all_nz   = (|bound_i) & (|bound_j) & (|bound_k);
  // row_q is the address of (i,0,0); col_q is the address of (i,j,0).
  assign next_col = col_q + sj_q;
  assign next_row = row_q + si_q;

  always_comb begin
    state_d = state_q;
    bi_d    = bi_q;
    bj_d    = bj_q;
    bk_d    = bk_q;
    si_d    = si_q;
    sj_d    = sj_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    row_d   = row_q;
    col_d   = col_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (all_nz) begin
            bi_d    = bound_i;
            bj_d    = bound_j;
            bk_d    = bound_k;
            si_d    = stride_i;
            sj_d    = stride_j;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            row_d   = base;
            col_d   = base;
            addr_d  = base;
            state_d = S_RUN;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        // out_valid is always high in RUN, so out_ready alone means acceptance.
        if (abort) begin
          state_d = S_IDLE;
        end else if (out_ready) begin
          if (!k_end) begin
            k_d    = k_q + ONE;
            addr_d = addr_q + ONE;
          end else if (!j_end) begin
            k_d    = '0;
            j_d    = j_q + ONE;
            col_d  = next_col;
            addr_d = next_col;
          end else if (!i_end) begin
            k_d    = '0;
            j_d    = '0;
            i_d    = i_q + ONE;
            row_d  = next_row;
            col_d  = next_row;
            addr_d = next_row;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      bi_q    <= '0;
      bj_q    <= '0;
      bk_q    <= '0;
      si_q    <= '0;
      sj_q    <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      row_q   <= '0;
      col_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      bi_q    <= bi_d;
      bj_q    <= bj_d;
      bk_q    <= bk_d;
      si_q    <= si_d;
      sj_q    <= sj_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      row_q   <= row_d;
      col_q   <= col_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid = (state_q == S_RUN);
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign last      = out_valid & i_end & j_end & k_end;
  assign idx_i     = i_q;
  assign idx_j     = j_q;
  assign idx_k     = k_q;
  assign addr      = addr_q;

endmodule

// File: tb/tb_loop_nest_agu.sv
// Randomized bench for loop_nest_agu; expected beats come from a plain
// nested-loop model computing base + i*stride_i + j*stride_j + k.
module tb_loop_nest_agu;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rstn, start, abort, out_ready;
  logic [W-1:0] bound_i, bound_j, bound_k, base, stride_i, stride_j;
  logic         out_valid, last, busy, done;
  logic [W-1:0] idx_i, idx_j, idx_k, addr;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] i, j, k, a;
    logic         l;
  } beat_t;

  beat_t        expq[$];
  logic [W-1:0] obs_addr[$];

  always #5 clk = ~clk;

  loop_nest_agu #(.W(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .bound_i(bound_i), .bound_j(bound_j), .bound_k(bound_k),
    .base(base), .stride_i(stride_i), .stride_j(stride_j),
    .out_ready(out_ready), .out_valid(out_valid),
    .idx_i(idx_i), .idx_j(idx_j), .idx_k(idx_k), .addr(addr),
    .last(last), .busy(busy), .done(done)
  );

  function automatic void build_model(input logic [W-1:0] bi, bj, bk, b, si, sj);
    beat_t x;
    expq.delete();
    for (int i = 0; i < int'(bi); i++)
      for (int j = 0; j < int'(bj); j++)
        for (int k = 0; k < int'(bk); k++) begin
          x.i = W'(i);
          x.j = W'(j);
          x.k = W'(k);
          x.a = b + x.i * si + x.j * sj + x.k;
          x.l = (i == int'(bi) - 1) && (j == int'(bj) - 1) && (k == int'(bk) - 1);
          expq.push_back(x);
        end
  endfunction

  task automatic start_nest(input logic [W-1:0] bi, bj, bk, b, si, sj);
    bound_i  = bi;
    bound_j  = bj;
    bound_k  = bk;
    base     = b;
    stride_i = si;
    stride_j = sj;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    abort = 1'b0;
  endtask

  // rpct >= 0: percent chance of ready; rpct < 0: ready pattern 1,0,0,1,0,0,...
  task automatic run_nest(input logic [W-1:0] bi, bj, bk, b, si, sj,
                          input int rpct, input bit noisy, output int cyc);
    beat_t        h;
    bit           stalled = 1'b0;
    bit           rdy;
    logic [W-1:0] s_i, s_j, s_k, s_a;
    logic         s_l;
    int           limit = 4000;
    build_model(bi, bj, bk, b, si, sj);
    obs_addr.delete();
    start_nest(bi, bj, bk, b, si, sj);
    cyc = 0;
    while (expq.size() > 0 && cyc < limit) begin
      h = expq[0];
      tests++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || idx_i !== h.i || idx_j !== h.j ||
          idx_k !== h.k || addr !== h.a || last !== h.l) begin
        fails++;
        $display("FAIL beat: got v=%b i=%0d j=%0d k=%0d addr=%h last=%b, expected v=1 i=%0d j=%0d k=%0d addr=%h last=%b",
                 out_valid, idx_i, idx_j, idx_k, addr, last, h.i, h.j, h.k, h.a, h.l);
      end
      if (stalled) begin
        tests++;
        if ({idx_i, idx_j, idx_k, addr, last} !== {s_i, s_j, s_k, s_a, s_l}) begin
          fails++;
          $display("FAIL stall_hold: got addr=%h k=%0d, expected addr=%h k=%0d", addr, idx_k, s_a, s_k);
        end
      end
      if (rpct < 0) rdy = (cyc % 3 == 0);
      else          rdy = (int'($urandom_range(99)) < rpct);
      out_ready = rdy;
      if (noisy) begin
        start   = 1'($urandom_range(1));
        bound_i = $urandom;
        bound_k = $urandom;
        base    = $urandom;
      end
      s_i = idx_i; s_j = idx_j; s_k = idx_k; s_a = addr; s_l = last;
      @(posedge clk); #1;
      cyc++;
      if (rdy) begin
        obs_addr.push_back(s_a);
        void'(expq.pop_front());
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tests++;
    if (cyc >= limit) begin
      fails++;
      $display("FAIL timeout: %0d beats still pending, expected 0", expq.size());
    end
    tests++;
    if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_pulse: got v=%b done=%b busy=%b, expected v=0 done=1 busy=0", out_valid, done, busy);
    end
    @(posedge clk); #1;
    tests++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL done_width: got done=%b v=%b, expected done=0 v=0", done, out_valid);
    end
  endtask

  task automatic check_addr_table(input string name, input logic [W-1:0] tbl[$]);
    tests++;
    if (obs_addr.size() != tbl.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d beats, expected %0d", name, obs_addr.size(), tbl.size());
    end else begin
      for (int n = 0; n < tbl.size(); n++) begin
        tests++;
        if (obs_addr[n] !== tbl[n]) begin
          fails++;
          $display("FAIL %s_addr%0d: got %h, expected %h", name, n, obs_addr[n], tbl[n]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1;
    bound_i = '0; bound_j = '0; bound_k = '0; base = '0; stride_i = '0; stride_j = '0;
    #2 rstn = 1'b0;
    #1;
    tests++;
    if ({out_valid, last, busy, done} !== 4'b0 || {idx_i, idx_j, idx_k, addr} !== '0) begin
      fails++;
      $display("FAIL reset_state: got v=%b last=%b busy=%b done=%b addr=%h, expected all 0",
               out_valid, last, busy, done, addr);
    end
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;
    @(posedge clk); #1;
    tests++;
    if ({out_valid, busy, done} !== 3'b0) begin
      fails++;
      $display("FAIL idle_after_reset: got v=%b busy=%b done=%b, expected 0", out_valid, busy, done);
    end
  endtask

  task automatic test_basic();
    int           cyc;
    logic [W-1:0] tbl[$] = '{100, 101, 102, 110, 111, 112, 150, 151, 152, 160, 161, 162};
    run_nest(2, 2, 3, 100, 50, 10, 100, 1'b0, cyc);
    tests++;
    if (cyc != 12) begin
      fails++;
      $display("FAIL basic_cycles: got %0d, expected 12", cyc);
    end
    check_addr_table("basic", tbl);
  endtask

  task automatic test_stall();
    int           cyc;
    logic [W-1:0] tbl[$] = '{100, 101, 102, 110, 111, 112, 150, 151, 152, 160, 161, 162};
    run_nest(2, 2, 3, 100, 50, 10, -1, 1'b0, cyc);
    check_addr_table("stall", tbl);
    run_nest(3, 2, 2, $urandom, $urandom, $urandom, 40, 1'b0, cyc);
  endtask

  task automatic test_zero_bound();
    for (int z = 0; z < 3; z++) begin
      int done_cnt = 0;
      int first_done = -1;
      bit v_seen = 1'b0;
      bit b_seen = 1'b0;
      start_nest(z == 0 ? 0 : 3, z == 1 ? 0 : 2, z == 2 ? 0 : 4, 7, 8, 9);
      for (int c = 0; c < 5; c++) begin
        if (done === 1'b1) begin
          done_cnt++;
          if (first_done < 0) first_done = c;
        end
        if (out_valid !== 1'b0) v_seen = 1'b1;
        if (busy !== 1'b0) b_seen = 1'b1;
        @(posedge clk); #1;
      end
      tests++;
      if (done_cnt != 1 || first_done < 0 || first_done > 1 || v_seen || b_seen) begin
        fails++;
        $display("FAIL zero_bound%0d: got done_cnt=%0d at=%0d v=%b busy=%b, expected done_cnt=1 at<=1 v=0 busy=0",
                 z, done_cnt, first_done, v_seen, b_seen);
      end
    end
  endtask

  task automatic test_abort();
    beat_t h;
    int    cyc;
    build_model(2, 2, 3, 100, 50, 10);
    start_nest(2, 2, 3, 100, 50, 10);
    for (int n = 0; n < 5; n++) begin
      h = expq[0];
      tests++;
      if (out_valid !== 1'b1 || addr !== h.a || idx_k !== h.k || idx_j !== h.j) begin
        fails++;
        $display("FAIL abort_pre%0d: got v=%b addr=%h, expected v=1 addr=%h", n, out_valid, addr, h.a);
      end
      out_ready = 1'b1;
      abort = (n == 4);
      @(posedge clk); #1;
      abort = 1'b0;
      void'(expq.pop_front());
    end
    tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("FAIL abort_stop: got v=%b busy=%b done=%b, expected 0 0 0", out_valid, busy, done);
    end
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests++;
      if (done !== 1'b0 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL abort_nodone%0d: got done=%b v=%b, expected 0 0", c, done, out_valid);
      end
    end
    // abort held high while idle must not block the next start
    abort = 1'b1;
    run_nest(2, 3, 2, $urandom, $urandom, $urandom, 100, 1'b0, cyc);
  endtask

  task automatic test_wrap();
    int           cyc;
    logic [W-1:0] tbl[$] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    run_nest(1, 1, 4, 32'hFFFF_FFFE, $urandom, $urandom, 70, 1'b0, cyc);
    check_addr_table("wrap", tbl);
    run_nest(3, 3, 2, 32'hFFFF_FF00, 32'h8000_0000, 32'h7FFF_FFF0, 80, 1'b0, cyc);
  endtask

  task automatic test_random();
    int cyc;
    for (int r = 0; r < 8; r++)
      run_nest($urandom_range(4, 1), $urandom_range(4, 1), $urandom_range(4, 1),
               $urandom, $urandom, $urandom, 60, 1'b1, cyc);
  endtask

  task automatic test_async_reset();
    int cyc;
    start_nest(3, 3, 3, 32'h1234, 5, 7);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #3 rstn = 1'b0;
    #1;
    tests++;
    if ({out_valid, last, busy, done} !== 4'b0 || {idx_i, idx_j, idx_k, addr} !== '0) begin
      fails++;
      $display("FAIL async_reset: got v=%b busy=%b done=%b addr=%h k=%0d, expected all 0",
               out_valid, busy, done, addr, idx_k);
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      tests++;
      if ({out_valid, busy, done} !== 3'b0) begin
        fails++;
        $display("FAIL post_reset_idle%0d: got v=%b busy=%b done=%b, expected 0", c, out_valid, busy, done);
      end
    end
    run_nest(2, 2, 2, 32'h40, 32'h100, 32'h10, 100, 1'b0, cyc);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_zero_bound();
    test_abort();
    test_wrap();
    test_random();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
